// File: rtl/fetch_decode_fsm.sv
// fetch_decode_fsm
// Instruction fetch/decode sequencer. Fetches one 16-bit word from program
// memory, latches opcode/param1/param2, and hands the instruction to the ALU,
// memory or branch execution FSM with a one-cycle activate pulse. It then
// waits for that FSM's done pulse before fetching the next word. NOP and
// HALT are handled locally. Fetch and execution stalls end in a sticky fault.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-low reset
//   start        run request (honoured in IDLE and HALT only)
//   memRdy       program memory word valid on memData
//   memData      instruction word: [15:12] opcode, [11:6] param1, [5:0] param2
//   doneALU/doneMem/doneBr  single-cycle done pulses from execution FSMs
//   pcOut        drive PC onto program address bus (FETCH)
//   memRead      program memory read strobe (FETCH)
//   opcode/param1/param2    registered instruction fields
//   actALU/actMem/actBr     one-cycle activate pulses
//   pcInc        one-cycle PC increment (NOP, HALT resume)
//   halted       HALT state
//   fault        fault state; faultCode: 01 fetch timeout, 10 exec timeout,
//                11 illegal opcode
//   instrCount   retired-instruction counter (wraps)
module fetch_decode_fsm #(
    parameter int FETCH_TO = 15,
    parameter int EXEC_TO  = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        memRdy,
    input  logic [15:0] memData,
    input  logic        doneALU,
    input  logic        doneMem,
    input  logic        doneBr,
    output logic        pcOut,
    output logic        memRead,
    output logic [3:0]  opcode,
    output logic [5:0]  param1,
    output logic [5:0]  param2,
    output logic        actALU,
    output logic        actMem,
    output logic        actBr,
    output logic        pcInc,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  faultCode,
    output logic [15:0] instrCount
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_DISPATCH, S_WAIT, S_NOP_INC, S_HALT, S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        C_ALU, C_MEM, C_BR
    } class_t;

    localparam logic [7:0] FETCH_LIM = 8'(FETCH_TO);
    localparam logic [7:0] EXEC_LIM  = 8'(EXEC_TO);

    state_t     state;
    class_t     cls;       // class of the instruction currently in flight
    logic [7:0] cnt;       // cycles spent in FETCH or WAIT, 0 on the first cycle
    logic       done_match;

    // Only the done pulse from the FSM that was activated retires the op.
    always_comb begin
        done_match = 1'b0;
        case (cls)
            C_ALU:   done_match = doneALU;
            C_MEM:   done_match = doneMem;
            C_BR:    done_match = doneBr;
            default: done_match = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            cls        <= C_ALU;
            cnt        <= 8'd0;
            pcOut      <= 1'b0;
            memRead    <= 1'b0;
            opcode     <= 4'd0;
            param1     <= 6'd0;
            param2     <= 6'd0;
            actALU     <= 1'b0;
            actMem     <= 1'b0;
            actBr      <= 1'b0;
            pcInc      <= 1'b0;
            halted     <= 1'b0;
            fault      <= 1'b0;
            faultCode  <= 2'b00;
            instrCount <= 16'd0;
        end else begin
            // Strobes and pulses are re-asserted only by the transition that
            // enters the state owning them, so they drop automatically.
            pcOut   <= 1'b0;
            memRead <= 1'b0;
            actALU  <= 1'b0;
            actMem  <= 1'b0;
            actBr   <= 1'b0;
            pcInc   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_FETCH;
                        pcOut   <= 1'b1;
                        memRead <= 1'b1;
                        cnt     <= 8'd0;
                    end
                end

                S_FETCH: begin
                    // An accept on the final allowed cycle beats the timeout.
                    if (memRdy) begin
                        opcode <= memData[15:12];
                        param1 <= memData[11:6];
                        param2 <= memData[5:0];
                        state  <= S_DECODE;
                    end else if (cnt == FETCH_LIM) begin
                        state     <= S_FAULT;
                        fault     <= 1'b1;
                        faultCode <= 2'b01;
                    end else begin
                        cnt     <= cnt + 8'd1;
                        pcOut   <= 1'b1;
                        memRead <= 1'b1;
                    end
                end

                S_DECODE: begin
                    case (opcode) inside
                        4'h0: begin
                            state      <= S_NOP_INC;
                            pcInc      <= 1'b1;
                            instrCount <= instrCount + 16'd1;
                        end
                        [4'h1:4'h7]: begin
                            state  <= S_DISPATCH;
                            cls    <= C_ALU;
                            actALU <= 1'b1;
                        end
                        [4'h8:4'h9]: begin
                            state  <= S_DISPATCH;
                            cls    <= C_MEM;
                            actMem <= 1'b1;
                        end
                        [4'hA:4'hB]: begin
                            state <= S_DISPATCH;
                            cls   <= C_BR;
                            actBr <= 1'b1;
                        end
                        4'hF: begin
                            state      <= S_HALT;
                            halted     <= 1'b1;
                            instrCount <= instrCount + 16'd1;
                        end
                        default: begin
                            state     <= S_FAULT;
                            fault     <= 1'b1;
                            faultCode <= 2'b11;
                        end
                    endcase
                end

                S_DISPATCH: begin
                    state <= S_WAIT;
                    cnt   <= 8'd0;
                end

                S_WAIT: begin
                    // A done on the final allowed cycle beats the timeout.
                    if (done_match) begin
                        state      <= S_FETCH;
                        pcOut      <= 1'b1;
                        memRead    <= 1'b1;
                        cnt        <= 8'd0;
                        instrCount <= instrCount + 16'd1;
                    end else if (cnt == EXEC_LIM) begin
                        state     <= S_FAULT;
                        fault     <= 1'b1;
                        faultCode <= 2'b10;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                S_NOP_INC: begin
                    state   <= S_FETCH;
                    pcOut   <= 1'b1;
                    memRead <= 1'b1;
                    cnt     <= 8'd0;
                end

                S_HALT: begin
                    // Resuming steps the PC past the HALT word; the HALT was
                    // already counted on entry.
                    if (start) begin
                        state  <= S_NOP_INC;
                        pcInc  <= 1'b1;
                        halted <= 1'b0;
                    end
                end

                S_FAULT: begin
                    state <= S_FAULT;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode_fsm.sv
module tb_fetch_decode_fsm;

    logic        clk;
    logic        rst;
    logic        start;
    logic        memRdy;
    logic [15:0] memData;
    logic        doneALU, doneMem, doneBr;
    logic        pcOut, memRead;
    logic [3:0]  opcode;
    logic [5:0]  param1, param2;
    logic        actALU, actMem, actBr;
    logic        pcInc, halted, fault;
    logic [1:0]  faultCode;
    logic [15:0] instrCount;

    int checks = 0;
    int passed = 0;

    fetch_decode_fsm #(.FETCH_TO(15), .EXEC_TO(63)) dut (
        .clk(clk), .rst(rst), .start(start), .memRdy(memRdy), .memData(memData),
        .doneALU(doneALU), .doneMem(doneMem), .doneBr(doneBr),
        .pcOut(pcOut), .memRead(memRead), .opcode(opcode), .param1(param1),
        .param2(param2), .actALU(actALU), .actMem(actMem), .actBr(actBr),
        .pcInc(pcInc), .halted(halted), .fault(fault), .faultCode(faultCode),
        .instrCount(instrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled at the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [9:0]  ctl;
        logic [15:0] ir;
        logic [2:0]  acts;
        rst = 1'b0; start = 1'b1; memRdy = 1'b1; memData = 16'h1083;
        repeat (3) tick();
        ctl = {pcOut, memRead, actALU, actMem, actBr, pcInc, halted, fault, faultCode};
        ir  = {opcode, param1, param2};
        checks++; if (ctl !== 10'd0) $display("FAIL reset_ctl: got %b want %b", ctl, 10'd0); else passed++;
        checks++; if (ir !== 16'd0) $display("FAIL reset_ir: got %h want %h", ir, 16'd0); else passed++;
        checks++; if (instrCount !== 16'd0) $display("FAIL reset_count: got %h want %h", instrCount, 16'd0); else passed++;
        // Release: edge 0 sees start, FETCH in cycle 1.
        rst = 1'b1;
        tick();
        checks++; if ({pcOut, memRead} !== 2'b11) $display("FAIL first_fetch: got %b want %b", {pcOut, memRead}, 2'b11); else passed++;
        tick(); // cycle 2, DECODE
        ir = {opcode, param1, param2};
        checks++; if (ir !== 16'h1083) $display("FAIL ir_fields: got %h want %h", ir, 16'h1083); else passed++;
        checks++; if (param1 !== 6'd2 || param2 !== 6'd3) $display("FAIL params: got %0d/%0d want 2/3", param1, param2); else passed++;
        checks++; if (actALU !== 1'b0) $display("FAIL act_early: got %b want 0", actALU); else passed++;
        memRdy = 1'b0;
        tick(); // cycle 3, DISPATCH
        acts = {actALU, actMem, actBr};
        checks++; if (acts !== 3'b100) $display("FAIL act_alu_c3: got %b want %b", acts, 3'b100); else passed++;
        tick(); // cycle 4, WAIT
        acts = {actALU, actMem, actBr};
        checks++; if (acts !== 3'b000) $display("FAIL act_alu_c4: got %b want %b", acts, 3'b000); else passed++;
        repeat (6) tick(); // cycle 10
        checks++; if (pcOut !== 1'b0) $display("FAIL still_wait: got %b want 0", pcOut); else passed++;
        doneALU = 1'b1;
        tick(); // cycle 11
        doneALU = 1'b0;
        start = 1'b0;
        checks++; if (pcOut !== 1'b1) $display("FAIL fetch_c11: got %b want 1", pcOut); else passed++;
        checks++; if (instrCount !== 16'd1) $display("FAIL count_c11: got %h want %h", instrCount, 16'd1); else passed++;
    endtask

    task automatic test_sequence();
        logic [2:0] acts;
        // NOP
        memRdy = 1'b1; memData = 16'h0000;
        tick(); memRdy = 1'b0;
        tick();
        checks++; if (pcInc !== 1'b1) $display("FAIL nop_pcinc: got %b want 1", pcInc); else passed++;
        checks++; if (instrCount !== 16'd2) $display("FAIL nop_count: got %h want %h", instrCount, 16'd2); else passed++;
        tick();
        checks++; if ({pcInc, pcOut} !== 2'b01) $display("FAIL nop_exit: got %b want %b", {pcInc, pcOut}, 2'b01); else passed++;
        // memory op
        memRdy = 1'b1; memData = 16'h8041;
        tick(); memRdy = 1'b0;
        checks++; if ({opcode, param1, param2} !== 16'h8041) $display("FAIL mem_ir: got %h want %h", {opcode, param1, param2}, 16'h8041); else passed++;
        tick();
        acts = {actALU, actMem, actBr};
        checks++; if (acts !== 3'b010) $display("FAIL act_mem: got %b want %b", acts, 3'b010); else passed++;
        tick();
        doneALU = 1'b1;
        tick(); doneALU = 1'b0;
        checks++; if ({pcOut, instrCount} !== {1'b0, 16'd2}) $display("FAIL wrong_done: got %b/%h want 0/%h", pcOut, instrCount, 16'd2); else passed++;
        doneMem = 1'b1;
        tick(); doneMem = 1'b0;
        checks++; if ({pcOut, instrCount} !== {1'b1, 16'd3}) $display("FAIL mem_retire: got %b/%h want 1/%h", pcOut, instrCount, 16'd3); else passed++;
        // branch op
        memRdy = 1'b1; memData = 16'hA000;
        tick(); memRdy = 1'b0;
        tick();
        acts = {actALU, actMem, actBr};
        checks++; if (acts !== 3'b001) $display("FAIL act_br: got %b want %b", acts, 3'b001); else passed++;
        tick();
        checks++; if ({actALU, actMem, actBr} !== 3'b000) $display("FAIL act_br_once: got %b want 000", {actALU, actMem, actBr}); else passed++;
        doneBr = 1'b1;
        tick(); doneBr = 1'b0;
        checks++; if ({pcOut, instrCount} !== {1'b1, 16'd4}) $display("FAIL br_retire: got %b/%h want 1/%h", pcOut, instrCount, 16'd4); else passed++;
    endtask

    task automatic test_halt();
        memRdy = 1'b1; memData = 16'hF000;
        tick(); memRdy = 1'b0;
        tick();
        checks++; if ({halted, instrCount} !== {1'b1, 16'd5}) $display("FAIL halt_entry: got %b/%h want 1/%h", halted, instrCount, 16'd5); else passed++;
        tick();
        checks++; if ({halted, pcOut, pcInc} !== 3'b100) $display("FAIL halt_hold: got %b want 100", {halted, pcOut, pcInc}); else passed++;
        start = 1'b1;
        tick(); start = 1'b0;
        checks++; if ({halted, pcInc, instrCount} !== {2'b01, 16'd5}) $display("FAIL halt_resume: got %b%b/%h want 01/%h", halted, pcInc, instrCount, 16'd5); else passed++;
        tick();
        checks++; if ({pcInc, pcOut, instrCount} !== {2'b01, 16'd5}) $display("FAIL resume_fetch: got %b%b/%h want 01/%h", pcInc, pcOut, instrCount, 16'd5); else passed++;
    endtask

    task automatic test_fetch_timeout();
        // In FETCH cycle 1 with memRdy low.
        repeat (15) tick();
        checks++; if ({fault, pcOut} !== 2'b01) $display("FAIL fetch_c16: got %b want 01", {fault, pcOut}); else passed++;
        tick();
        checks++; if ({fault, faultCode, pcOut} !== 4'b1010) $display("FAIL fetch_to: got %b want 1010", {fault, faultCode, pcOut}); else passed++;
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        checks++; if ({fault, faultCode, pcOut} !== 4'b1010) $display("FAIL fault_sticky: got %b want 1010", {fault, faultCode, pcOut}); else passed++;
        rst = 1'b0;
        tick();
        checks++; if ({fault, faultCode, instrCount} !== 19'd0) $display("FAIL fault1_rst: got %b/%h want 000/0000", {fault, faultCode}, instrCount); else passed++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fetch_boundary();
        start = 1'b1;
        tick(); start = 1'b0;
        repeat (15) tick(); // 16th FETCH cycle
        memRdy = 1'b1; memData = 16'h2000;
        tick(); memRdy = 1'b0;
        checks++; if ({fault, opcode} !== {1'b0, 4'h2}) $display("FAIL fetch_edge_accept: got %b/%h want 0/2", fault, opcode); else passed++;
        tick();
        checks++; if (actALU !== 1'b1) $display("FAIL fetch_edge_act: got %b want 1", actALU); else passed++;
        tick(); // WAIT cycle 1
    endtask

    task automatic test_exec_timeout();
        repeat (63) tick(); // 64th WAIT cycle
        checks++; if (fault !== 1'b0) $display("FAIL exec_c64: got %b want 0", fault); else passed++;
        doneALU = 1'b1;
        tick(); doneALU = 1'b0;
        checks++; if ({fault, pcOut, instrCount} !== {2'b01, 16'd1}) $display("FAIL exec_edge_done: got %b%b/%h want 01/%h", fault, pcOut, instrCount, 16'd1); else passed++;
        memRdy = 1'b1; memData = 16'h7FFF;
        tick(); memRdy = 1'b0;
        checks++; if ({param1, param2} !== 12'hFFF) $display("FAIL ir_max: got %h want %h", {param1, param2}, 12'hFFF); else passed++;
        tick();
        tick();
        repeat (63) tick();
        checks++; if (fault !== 1'b0) $display("FAIL exec_pre_to: got %b want 0", fault); else passed++;
        tick();
        checks++; if ({fault, faultCode, instrCount} !== {3'b110, 16'd1}) $display("FAIL exec_to: got %b/%h want 110/%h", {fault, faultCode}, instrCount, 16'd1); else passed++;
        rst = 1'b0;
        tick();
        checks++; if ({fault, faultCode, pcOut, opcode} !== 8'd0) $display("FAIL fault2_rst: got %b want 0", {fault, faultCode, pcOut, opcode}); else passed++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_illegal();
        start = 1'b1;
        tick(); start = 1'b0;
        memRdy = 1'b1; memData = 16'hD000;
        tick(); memRdy = 1'b0;
        tick();
        checks++; if ({fault, faultCode} !== 3'b111) $display("FAIL illegal_code: got %b want 111", {fault, faultCode}); else passed++;
        checks++; if ({actALU, actMem, actBr} !== 3'b000) $display("FAIL illegal_act: got %b want 000", {actALU, actMem, actBr}); else passed++;
        rst = 1'b0;
        tick();
        checks++; if ({fault, faultCode} !== 3'b000) $display("FAIL fault3_rst: got %b want 000", {fault, faultCode}); else passed++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        // Preload the counter just below the wrap point while idle.
        force dut.instrCount = 16'hFFFE;
        tick();
        release dut.instrCount;
        tick();
        start = 1'b1;
        tick(); start = 1'b0;
        memRdy = 1'b1; memData = 16'h0000;
        tick(); memRdy = 1'b0;
        tick();
        checks++; if (instrCount !== 16'hFFFF) $display("FAIL wrap_ffff: got %h want %h", instrCount, 16'hFFFF); else passed++;
        tick();
        memRdy = 1'b1;
        tick(); memRdy = 1'b0;
        tick();
        checks++; if (instrCount !== 16'h0000) $display("FAIL wrap_zero: got %h want %h", instrCount, 16'h0000); else passed++;
        tick(); // FETCH
    endtask

    task automatic test_reset_mid_wait();
        memRdy = 1'b1; memData = 16'h9ABC;
        tick(); memRdy = 1'b0;
        checks++; if ({opcode, param1, param2} !== {4'h9, 6'd42, 6'd60}) $display("FAIL ir_9abc: got %h/%0d/%0d want 9/42/60", opcode, param1, param2); else passed++;
        tick();
        checks++; if (actMem !== 1'b1) $display("FAIL act_mem2: got %b want 1", actMem); else passed++;
        tick(); // WAIT
        rst = 1'b0;
        tick();
        checks++; if ({pcOut, memRead, actALU, actMem, actBr, pcInc, halted, fault, faultCode, opcode, param1, param2, instrCount} !== 42'd0)
            $display("FAIL wait_rst: got %h want 0", {pcOut, memRead, actALU, actMem, actBr, pcInc, halted, fault, faultCode, opcode, param1, param2, instrCount});
        else passed++;
        rst = 1'b1; doneMem = 1'b1;
        tick(); doneMem = 1'b0;
        checks++; if ({pcOut, instrCount} !== 17'd0) $display("FAIL stray_done: got %b/%h want 0/0000", pcOut, instrCount); else passed++;
        // Reset during DECODE must suppress the pending activate.
        start = 1'b1;
        tick(); start = 1'b0;
        memRdy = 1'b1; memData = 16'h1000;
        tick(); memRdy = 1'b0;
        rst = 1'b0;
        tick();
        checks++; if ({actALU, actMem, actBr} !== 3'b000) $display("FAIL decode_rst_act: got %b want 000", {actALU, actMem, actBr}); else passed++;
        rst = 1'b1;
        tick();
        checks++; if ({actALU, pcOut} !== 2'b00) $display("FAIL decode_rst_idle: got %b want 00", {actALU, pcOut}); else passed++;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; memRdy = 1'b0; memData = 16'h0000;
        doneALU = 1'b0; doneMem = 1'b0; doneBr = 1'b0;
        tick();
        test_reset();
        test_sequence();
        test_halt();
        test_fetch_timeout();
        test_fetch_boundary();
        test_exec_timeout();
        test_illegal();
        test_wrap();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
